fp_int_converter: RTL and testbench

- Multi-cycle converter between IEEE-754 single precision and 32-bit two's-complement integer, on the FPU side of the CPU.
- Implements cvt.w.s (float->int, truncate toward zero) and cvt.s.w (int->float). It reads and writes the same FP word format the FPU ALU produces.
- Uses an iterative 1-bit/cycle shifter. Handshake is start/busy/done.

---
 rtl/fp_pkg.sv | 41 ++++
 rtl/fp_int_converter_if.sv | 33 +++
 rtl/fp_round_pack.sv | 40 ++++
 rtl/fp_int_converter.sv | 181 ++++++++++++++++++
 tb/tb_fp_int_converter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared constants, op/state encodings and a leading-zero helper
// for the float<->int converter.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [EXP_W-1:0] EXP_BIAS = 8'd127;
  localparam logic [31:0] INVALID_INT = 32'h7FFF_FFFF;
  localparam logic [31:0] NEG_2_31_FP = 32'hCF00_0000;

  typedef enum logic {
    CVT_W_S = 1'b0,
    CVT_S_W = 1'b1
  } cvt_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UNPACK,
    S_SHIFT,
    S_PACK
  } cvt_state_e;

  // Leading zeros of a non-zero word (0..31).
  function automatic logic [4:0] lzc32(
    input logic [31:0] v
  );
    logic [4:0] n;
    logic       hit;
    n   = '0;
    hit = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!hit) begin
        if (v[i]) hit = 1'b1;
        else      n   = n + 5'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_int_converter_if.sv
// fp_int_converter_if: start/busy/done request bundle.
// master drives start/op/a; slave returns out/busy/done/invalid.
interface fp_int_converter_if;

  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] out;
  logic        busy;
  logic        done;
  logic        invalid;

  modport master (
    output start,
    output op,
    output a,
    input  out,
    input  busy,
    input  done,
    input  invalid
  );

  modport slave (
    input  start,
    input  op,
    input  a,
    output out,
    output busy,
    output done,
    output invalid
  );

endinterface

// File: rtl/fp_round_pack.sv
// fp_round_pack: packs sign/exponent/normalized magnitude into a float.
// FP_CVT_ROUND_EN selects RNE rounding, otherwise bits [7:0] truncate.
import fp_pkg::*;

module fp_round_pack (
  input  logic             sign,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [31:0]      mag,
  output logic [31:0]      fp
);

  logic             round_up;
  logic [23:0]      sum;
  logic [EXP_W-1:0] exp_out;

`ifdef FP_CVT_ROUND_EN
  logic guard;
  logic sticky;
  logic lsb;
  logic unused_bits;

  assign guard       = mag[7];
  assign sticky      = |mag[6:0];
  assign lsb         = mag[8];
  assign round_up    = guard & (sticky | lsb);
  // bit31 is the implicit one after normalization
  assign unused_bits = mag[31];
`else
  logic unused_bits;

  assign round_up    = 1'b0;
  assign unused_bits = ^{mag[31], mag[7:0]};
`endif

  // carry out of the mantissa bumps the exponent; fraction is then zero
  assign sum     = {1'b0, mag[30:8]} + {23'd0, round_up};
  assign exp_out = exp_in + {{(EXP_W-1){1'b0}}, sum[23]};
  assign fp      = {sign, exp_out, sum[22:0]};

endmodule

// File: rtl/fp_int_converter.sv
// fp_int_converter: multi-cycle cvt.w.s / cvt.s.w with a 1-bit/cycle
// shifter; start/busy/done handshake. Macro: FP_CVT_ROUND_EN.
import fp_pkg::*;

module fp_int_converter (
  input  logic                cpu_clk,
  input  logic                reset_n,
  fp_int_converter_if.slave   cvt
);

  localparam logic [7:0] RSH_BASE = EXP_BIAS + 8'(FRAC_W);
  localparam logic [7:0] OVF_EXP  = EXP_BIAS + 8'd31;

  cvt_state_e       state_q, state_d;
  cvt_op_e          op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic             sign_q, sign_d;
  logic [31:0]      work_q, work_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             left_q, left_d;
  logic             inv_q, inv_d;
  logic             zero_q, zero_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [31:0]      out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             invalid_q, invalid_d;

  logic [7:0]  a_exp;
  logic [31:0] a_mant;
  logic [31:0] a_mag;
  logic [4:0]  a_lz;
  logic        f_ovf;
  logic        f_small;
  logic        f_right;
  logic [31:0] f2i_res;
  logic [31:0] i2f_fp;
  logic [31:0] i2f_res;

  assign a_exp  = a_q[30:23];
  assign a_mant = {8'd0, 1'b1, a_q[22:0]};
  assign a_mag  = a_q[31] ? (~a_q + 32'd1) : a_q;
  assign a_lz   = lzc32(a_mag);

  assign f_ovf   = a_exp >= OVF_EXP;
  assign f_small = a_exp < EXP_BIAS;
  assign f_right = (a_exp >= EXP_BIAS) && (a_exp <= RSH_BASE);

  assign f2i_res = inv_q  ? INVALID_INT :
                   sign_q ? (~work_q + 32'd1) : work_q;
  assign i2f_res = zero_q ? 32'd0 : i2f_fp;

  fp_round_pack u_pack (
    .sign   (sign_q),
    .exp_in (exp_q),
    .mag    (work_q),
    .fp     (i2f_fp)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    sign_d    = sign_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    inv_d     = inv_q;
    zero_d    = zero_q;
    exp_d     = exp_q;
    out_d     = out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    invalid_d = invalid_q;
    unique case (state_q)
      S_IDLE: begin
        if (cvt.start) begin
          a_d     = cvt.a;
          op_d    = cvt_op_e'(cvt.op);
          busy_d  = 1'b1;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sign_d = a_q[31];
        inv_d  = 1'b0;
        zero_d = 1'b0;
        left_d = 1'b0;
        cnt_d  = '0;
        work_d = '0;
        exp_d  = '0;
        if (op_q == CVT_W_S) begin
          unique case (1'b1)
            f_ovf: begin
              // -2^31 is the one representable e=31 value
              if (a_q == NEG_2_31_FP) work_d = 32'h8000_0000;
              else                    inv_d  = 1'b1;
            end
            f_small: begin
              work_d = '0;
            end
            f_right: begin
              work_d = a_mant;
              cnt_d  = 5'(RSH_BASE - a_exp);
            end
            default: begin
              work_d = a_mant;
              cnt_d  = 5'(a_exp - RSH_BASE);
              left_d = 1'b1;
            end
          endcase
        end else begin
          zero_d = (a_q == 32'd0);
          work_d = a_mag;
          left_d = 1'b1;
          cnt_d  = zero_d ? 5'd0 : a_lz;
          exp_d  = OVF_EXP - {3'd0, a_lz};
        end
        state_d = (cnt_d == 5'd0) ? S_PACK : S_SHIFT;
      end
      S_SHIFT: begin
        work_d = left_q ? (work_q << 1) : (work_q >> 1);
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = S_PACK;
      end
      S_PACK: begin
        if (op_q == CVT_W_S) begin
          out_d     = f2i_res;
          invalid_d = inv_q;
        end else begin
          out_d     = i2f_res;
          invalid_d = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= CVT_W_S;
      a_q       <= '0;
      sign_q    <= 1'b0;
      work_q    <= '0;
      cnt_q     <= '0;
      left_q    <= 1'b0;
      inv_q     <= 1'b0;
      zero_q    <= 1'b0;
      exp_q     <= '0;
      out_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      sign_q    <= sign_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      inv_q     <= inv_d;
      zero_q    <= zero_d;
      exp_q     <= exp_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      invalid_q <= invalid_d;
    end
  end

  assign cvt.out     = out_q;
  assign cvt.busy    = busy_q;
  assign cvt.done    = done_q;
  assign cvt.invalid = invalid_q;

endmodule

// File: tb/tb_fp_int_converter.sv
// tb_fp_int_converter: directed vectors against an arithmetic model,
// with a per-cycle compare of busy/done/out/invalid.
module tb_fp_int_converter;

  logic cpu_clk = 1'b0;
  logic reset_n = 1'b0;

  fp_int_converter_if cvt ();

  fp_int_converter dut (
    .cpu_clk (cpu_clk),
    .reset_n (reset_n),
    .cvt     (cvt)
  );

  always #5 cpu_clk = ~cpu_clk;

  int cyc = 0;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;
  bit          act = 1'b0;
  int          s_cyc = 0;
  int          d_cyc = 0;
  logic [31:0] e_out = '0;
  logic        e_inv = 1'b0;
  logic [31:0] held_out = '0;
  logic        held_inv = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               name, got, want, cyc);
    end
  endtask

  // float -> int from the value m * 2^(e-23), truncated toward zero
  function automatic void m_f2i(input  logic [31:0] a,
                                output logic [31:0] r,
                                output logic        inv,
                                output int          n);
    int              e;
    longint unsigned m;
    longint unsigned mag;
    e   = int'(a[30:23]) - 127;
    m   = 64'(a[22:0]) + 64'h80_0000;
    r   = '0;
    inv = 1'b0;
    n   = 0;
    if (a[30:23] == 8'hFF || e >= 31) begin
      if (a == 32'hCF00_0000) r = 32'h8000_0000;
      else begin
        r   = 32'h7FFF_FFFF;
        inv = 1'b1;
      end
    end else if (e >= 0) begin
      mag = (m << e) >> 23;
      n   = (e <= 23) ? 23 - e : e - 23;
      r   = a[31] ? 32'(-mag) : 32'(mag);
    end
  endfunction

  // int -> float from the position of the highest set bit
  function automatic void m_i2f(input  logic [31:0] a,
                                output logic [31:0] r,
                                output logic        inv,
                                output int          n);
    longint v;
    longint mag;
    longint q;
    int     p;
    int     be;
    int     sh;
`ifdef FP_CVT_ROUND_EN
    longint rem;
    longint half;
`endif
    r   = '0;
    inv = 1'b0;
    n   = 0;
    if (a != 0) begin
      v   = longint'($signed(a));
      mag = (v < 0) ? -v : v;
      p   = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) p = i;
      n  = 31 - p;
      be = 127 + p;
      if (p <= 23) q = mag << (23 - p);
      else begin
        sh = p - 23;
        q  = mag >> sh;
`ifdef FP_CVT_ROUND_EN
        rem  = mag - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
`endif
        if (q == (64'd1 << 24)) begin
          q  = q >> 1;
          be = be + 1;
        end
      end
      r = {a[31], 8'(be), q[22:0]};
    end
  endfunction

  always @(negedge cpu_clk) begin
    if (chk_en) begin
      if (act && cyc <= d_cyc) begin
        check("busy", 32'(cvt.busy),
              32'((cyc > s_cyc) && (cyc < d_cyc)));
        check("done", 32'(cvt.done), 32'(cyc == d_cyc));
        if (cyc == d_cyc) begin
          check("out", cvt.out, e_out);
          check("invalid", 32'(cvt.invalid), 32'(e_inv));
          held_out = e_out;
          held_inv = e_inv;
        end
      end else begin
        check("idle_busy", 32'(cvt.busy), 32'd0);
        check("idle_done", 32'(cvt.done), 32'd0);
        check("held_out", cvt.out, held_out);
        check("held_inv", 32'(cvt.invalid), 32'(held_inv));
      end
    end
  end

  task automatic run(input logic        op,
                     input logic [31:0] a,
                     input logic [31:0] want,
                     input logic        want_inv,
                     input int          want_n,
                     input bit          poke);
    logic [31:0] r;
    logic        inv;
    int          n;
    if (op) m_i2f(a, r, inv, n);
    else    m_f2i(a, r, inv, n);
    check("model_out", r, want);
    check("model_inv", 32'(inv), 32'(want_inv));
    check("model_lat", 32'(n), 32'(want_n));
    @(posedge cpu_clk); #1;
    cvt.start = 1'b1;
    cvt.op    = op;
    cvt.a     = a;
    s_cyc     = cyc;
    d_cyc     = cyc + n + 3;
    e_out     = r;
    e_inv     = inv;
    act       = 1'b1;
    @(posedge cpu_clk); #1;
    cvt.start = 1'b0;
    cvt.a     = $urandom;
    if (poke) begin
      repeat (2) @(posedge cpu_clk);
      #1;
      cvt.start = 1'b1;
      cvt.op    = ~op;
      cvt.a     = 32'h1234_5678;
      @(posedge cpu_clk); #1;
      cvt.start = 1'b0;
    end
    while (cyc <= d_cyc) begin
      @(posedge cpu_clk); #1;
    end
    act = 1'b0;
  endtask

  initial begin
    cvt.start = 1'b0;
    cvt.op    = 1'b0;
    cvt.a     = '0;
    repeat (3) @(posedge cpu_clk);
    #1;
    check("rst_out", cvt.out, 32'd0);
    check("rst_busy", 32'(cvt.busy), 32'd0);
    check("rst_done", 32'(cvt.done), 32'd0);
    check("rst_inv", 32'(cvt.invalid), 32'd0);
    chk_en  = 1'b1;
    reset_n = 1'b1;
    @(posedge cpu_clk); #1;

    run(1'b0, 32'h40A0_0000, 32'h0000_0005, 1'b0, 21, 1'b1);
    run(1'b0, 32'hC049_0FDB, 32'hFFFF_FFFD, 1'b0, 22, 1'b0);
    run(1'b0, 32'h3F00_0000, 32'h0000_0000, 1'b0, 0, 1'b0);
    run(1'b0, 32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 0, 1'b0);
    run(1'b0, 32'hCF00_0000, 32'h8000_0000, 1'b0, 0, 1'b0);
    run(1'b0, 32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 0, 1'b0);
    run(1'b0, 32'h4E80_0000, 32'h4000_0000, 1'b0, 7, 1'b0);
    run(1'b1, 32'h0000_0001, 32'h3F80_0000, 1'b0, 31, 1'b0);
    run(1'b1, 32'h8000_0000, 32'hCF00_0000, 1'b0, 0, 1'b0);
    run(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 0, 1'b0);
    run(1'b1, 32'hFFFF_FFFB, 32'hC0A0_0000, 1'b0, 29, 1'b0);
`ifdef FP_CVT_ROUND_EN
    run(1'b1, 32'h0100_0003, 32'h4B80_0002, 1'b0, 7, 1'b0);
    run(1'b1, 32'h7FFF_FFFF, 32'h4F00_0000, 1'b0, 1, 1'b0);
`else
    run(1'b1, 32'h0100_0003, 32'h4B80_0001, 1'b0, 7, 1'b0);
    run(1'b1, 32'h7FFF_FFFF, 32'h4EFF_FFFF, 1'b0, 1, 1'b0);
`endif

    // abort a long conversion in the middle of its shift phase
    @(posedge cpu_clk); #1;
    cvt.start = 1'b1;
    cvt.op    = 1'b1;
    cvt.a     = 32'h0000_0001;
    s_cyc     = cyc;
    d_cyc     = cyc + 34;
    act       = 1'b1;
    @(posedge cpu_clk); #1;
    cvt.start = 1'b0;
    repeat (8) @(posedge cpu_clk);
    #1;
    reset_n  = 1'b0;
    act      = 1'b0;
    held_out = '0;
    held_inv = 1'b0;
    #1;
    check("abort_out", cvt.out, 32'd0);
    check("abort_busy", 32'(cvt.busy), 32'd0);
    repeat (3) @(posedge cpu_clk);
    #1;
    reset_n = 1'b1;
    repeat (40) @(posedge cpu_clk);
    #1;

    run(1'b0, 32'h40A0_0000, 32'h0000_0005, 1'b0, 21, 1'b0);
    run(1'b1, 32'h0000_0001, 32'h3F80_0000, 1'b0, 31, 1'b0);

    @(posedge cpu_clk); #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
